seat_allocator: RTL and testbench
=================================

// Module: seat_allocator
// PURPOSE
//  Upstream stage of the seat table RAM. Accepts student seat requests (student no. + preferred seat)
//  and tracks seat occupancy. Assigns the preferred seat, or the next free seat (wrapping scan).
//  Issues a one-cycle write (student no., seat no.) to the seat table and a response to the requester.
//  Seats are freed via a release port.
// PARAMETERS
//  NUM_SEATS  32  number of seats; valid seat numbers are 0..NUM_SEATS-1 (max 256)
// PORTS
//  clk_alloc         in   1   single clock, rising edge
//  rst_n_alloc       in   1   asynchronous, active-low reset
//  req_valid         in   1   request present
//  req_ready         out  1   1 only in IDLE; request accepted when req_valid && req_ready
//  req_student_no    in   25  student number to seat
//  req_pref_seat     in   8   preferred seat; values >= NUM_SEATS are treated as 0
//  rel_valid         in   1   release seat rel_seat this cycle
//  rel_seat          in   8   seat to free; out-of-range is ignored
//  wr_en             out  1   one-cycle write strobe to seat table
//  wr_student_no     out  25  student number to write
//  wr_seat_no        out  8   seat number to write
//  resp_valid        out  1   one-cycle response pulse
//  resp_code         out  2   00 OK, 01 FULL, 10 DUP
//  resp_seat         out  8   assigned seat (0 when code != OK)
//  occ_count         out  $clog2(NUM_SEATS+1)  occupied seats
//  full              out  1   occ_count == NUM_SEATS
// BEHAVIOUR
//  Reset: state IDLE; occupancy map cleared; wr_*, resp_*, occ_count and full all 0; req_ready=1 after reset.
//   Reset mid-operation aborts the request with no write and no response.
//  FSM IDLE->CHECK->(SCAN)->WRITE->RESP->IDLE; FULL/DUP path is CHECK->RESP.
//   IDLE:  capture request on handshake.
//   CHECK: if full -> RESP/FULL. Elif DUP (see CONFIGURATION) -> RESP/DUP.
//          Elif pref free -> WRITE with seat=pref. Else ptr=(pref+1) mod NUM_SEATS -> SCAN.
//   SCAN:  examine one seat per cycle; free -> WRITE with that seat; else ptr wraps
//          NUM_SEATS-1 -> 0. Terminates within NUM_SEATS-1 cycles (not full at CHECK;
//          releases only free seats).
//   WRITE: wr_en=1 for one cycle; occupancy bit set in the same edge.
//   RESP:  resp_valid=1 for one cycle -> IDLE.
//  Latency (handshake edge = cycle 0): pref free -> wr_en cycle 2, resp_valid cycle 3.
//   Full -> resp_valid cycle 2, no wr_en. Each SCAN step adds 1 cycle.
//  Release: accepted in any state. Clears the bit; releasing a free or out-of-range seat is a no-op.
//   Release of another seat in the WRITE cycle: both apply, occ_count net unchanged.
//   A release seen during CHECK/SCAN is visible to the next seat examined.
//  occ_count/full are registered and updated on the same edge as the bitmap.
//  wr_student_no/wr_seat_no hold their last values when wr_en=0.
// CONFIGURATION
//  DUP_CHECK_EN defined: per-seat shadow register of the student no. plus valid bit (cleared on release/reset).
//   CHECK compares req_student_no against all valid entries in parallel; any match -> RESP/DUP, no write.
//   FULL takes priority over DUP.
//  DUP_CHECK_EN undefined: no shadow storage; resp_code never 10; duplicates get a second seat.
// STRUCTURE
//  seat_pkg: STUDENT_W=25, SEAT_W=8, student_no_t, seat_no_t, alloc_state_e, resp_code_e.
//  Sub-module seat_occ_map: bitmap, set/release arbitration, occ_count, full, free-bit lookup for a seat index.
//   seat_allocator holds the FSM, request capture, scan pointer and outputs.
// TESTING
//  Reset; req 1001 pref 5 -> wr_en cycle 2 seat 5, resp OK seat 5 cycle 3, occ_count=1.
//  Seat 5 held; req 1002 pref 5 -> one SCAN step, resp OK seat 6, resp_valid cycle 4.
//  Seats 31 and 0 held, 1 free; req pref 31 -> wraps, resp OK seat 1.
//  Fill all 32 -> full=1; req 2000 -> resp FULL cycle 2, no wr_en, occ_count stays 32.
//  31 held, seat 20 freed by rel during SCAN -> scan finds 20, resp OK seat 20; release of free seat 3 -> no change.
//  Assert rst_n_alloc during SCAN -> outputs 0, occ_count 0, no resp.
//   DUP_CHECK_EN: req 1001 twice -> second resp DUP; after rel of its seat, req 1001 -> OK.

Source files
------------

// File: rtl/seat_pkg.sv
// Shared types for the seat allocator slice: widths, FSM states, response codes.
package seat_pkg;

    localparam int unsigned STUDENT_W = 25;
    localparam int unsigned SEAT_W    = 8;

    typedef logic [STUDENT_W-1:0] student_no_t;
    typedef logic [SEAT_W-1:0]    seat_no_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SCAN,
        ST_WRITE,
        ST_RESP
    } alloc_state_e;

    typedef enum logic [1:0] {
        RESP_OK   = 2'b00,
        RESP_FULL = 2'b01,
        RESP_DUP  = 2'b10
    } resp_code_e;

    // Next seat index in a ring of n seats.
    function automatic seat_no_t seat_wrap_inc(input seat_no_t s, input int unsigned n);
        return (32'(s) + 1 >= n) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/seat_occ_map.sv
// Seat occupancy bitmap with set/release arbitration, occupied count, full flag
// and a free-bit lookup for one seat index.
module seat_occ_map
    import seat_pkg::*;
#(
    parameter int unsigned NUM_SEATS = 32,
    parameter int unsigned CNT_W     = $clog2(NUM_SEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  seat_no_t         set_seat,
    input  logic             rel_en,
    input  seat_no_t         rel_seat,
    input  seat_no_t         look_seat,
    output logic             look_free,
    output logic [CNT_W-1:0] occ_count,
    output logic             full
);

    logic [NUM_SEATS-1:0] occ;
    logic [NUM_SEATS-1:0] occ_nxt;
    logic                 rel_hit;
    logic [CNT_W-1:0]     cnt_nxt;

    // Out-of-range indices never match a bit, so they fall out as no-ops; a set
    // wins over a release of the same seat, which is free until this edge.
    always_comb begin
        occ_nxt   = occ;
        rel_hit   = 1'b0;
        look_free = 1'b0;
        for (int unsigned i = 0; i < NUM_SEATS; i++) begin
            occ_nxt[i] = (set_en && 32'(set_seat) == i) ||
                         (occ[i] && !(rel_en && 32'(rel_seat) == i));
            if (rel_en && 32'(rel_seat) == i && occ[i] && !(set_en && set_seat == rel_seat))
                rel_hit = 1'b1;
            if (32'(look_seat) == i)
                look_free = !occ[i];
        end
    end

    always_comb begin
        cnt_nxt = occ_count;
        if (set_en && !rel_hit)
            cnt_nxt = occ_count + CNT_W'(1);
        else if (!set_en && rel_hit)
            cnt_nxt = occ_count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= '0;
            occ_count <= '0;
            full      <= 1'b0;
        end else begin
            occ       <= occ_nxt;
            occ_count <= cnt_nxt;
            full      <= (cnt_nxt == CNT_W'(NUM_SEATS));
        end
    end

endmodule

// File: rtl/seat_allocator.sv
// Seat request front end: FSM, request capture, wrapping free-seat scan, seat table write
// and response. Define DUP_CHECK_EN to reject a student number that already holds a seat.
module seat_allocator
    import seat_pkg::*;
#(
    parameter int unsigned NUM_SEATS = 32
) (
    input  logic                           clk_alloc,
    input  logic                           rst_n_alloc,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [STUDENT_W-1:0]           req_student_no,
    input  logic [SEAT_W-1:0]              req_pref_seat,
    input  logic                           rel_valid,
    input  logic [SEAT_W-1:0]              rel_seat,
    output logic                           wr_en,
    output logic [STUDENT_W-1:0]           wr_student_no,
    output logic [SEAT_W-1:0]              wr_seat_no,
    output logic                           resp_valid,
    output logic [1:0]                     resp_code,
    output logic [SEAT_W-1:0]              resp_seat,
    output logic [$clog2(NUM_SEATS+1)-1:0] occ_count,
    output logic                           full
);

    localparam int unsigned CNT_W = $clog2(NUM_SEATS + 1);

    alloc_state_e state;
    student_no_t  stu_q;
    seat_no_t     pref_q;
    seat_no_t     ptr;
    seat_no_t     seat_q;
    seat_no_t     look_seat;
    resp_code_e   code_q;
    logic         look_free;
    logic         dup_hit;
    logic         write_now;

    assign req_ready = (state == ST_IDLE);
    assign write_now = (state == ST_WRITE);
    assign look_seat = (state == ST_SCAN) ? ptr : pref_q;

    seat_occ_map #(
        .NUM_SEATS(NUM_SEATS),
        .CNT_W    (CNT_W)
    ) u_occ_map (
        .clk      (clk_alloc),
        .rst_n    (rst_n_alloc),
        .set_en   (write_now),
        .set_seat (seat_q),
        .rel_en   (rel_valid),
        .rel_seat (rel_seat),
        .look_seat(look_seat),
        .look_free(look_free),
        .occ_count(occ_count),
        .full     (full)
    );

`ifdef DUP_CHECK_EN
    student_no_t          shadow_stu [NUM_SEATS];
    logic [NUM_SEATS-1:0] shadow_vld;

    always_ff @(posedge clk_alloc or negedge rst_n_alloc) begin
        if (!rst_n_alloc) begin
            shadow_vld <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SEATS; i++) begin
                if (write_now && 32'(seat_q) == i)
                    shadow_vld[i] <= 1'b1;
                else if (rel_valid && 32'(rel_seat) == i)
                    shadow_vld[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_alloc) begin
        for (int unsigned i = 0; i < NUM_SEATS; i++)
            if (write_now && 32'(seat_q) == i)
                shadow_stu[i] <= stu_q;
    end

    always_comb begin
        dup_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SEATS; i++)
            if (shadow_vld[i] && shadow_stu[i] == stu_q)
                dup_hit = 1'b1;
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_ff @(posedge clk_alloc or negedge rst_n_alloc) begin
        if (!rst_n_alloc) begin
            state         <= ST_IDLE;
            stu_q         <= '0;
            pref_q        <= '0;
            ptr           <= '0;
            seat_q        <= '0;
            code_q        <= RESP_OK;
            wr_en         <= 1'b0;
            wr_student_no <= '0;
            wr_seat_no    <= '0;
            resp_valid    <= 1'b0;
            resp_code     <= '0;
            resp_seat     <= '0;
        end else begin
            wr_en      <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        stu_q  <= req_student_no;
                        pref_q <= (32'(req_pref_seat) < NUM_SEATS) ? req_pref_seat : '0;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (full) begin
                        code_q <= RESP_FULL;
                        state  <= ST_RESP;
                    end else if (dup_hit) begin
                        code_q <= RESP_DUP;
                        state  <= ST_RESP;
                    end else if (look_free) begin
                        seat_q <= pref_q;
                        state  <= ST_WRITE;
                    end else begin
                        ptr   <= seat_wrap_inc(pref_q, NUM_SEATS);
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (look_free) begin
                        seat_q <= ptr;
                        state  <= ST_WRITE;
                    end else begin
                        ptr <= seat_wrap_inc(ptr, NUM_SEATS);
                    end
                end
                ST_WRITE: begin
                    wr_en         <= 1'b1;
                    wr_student_no <= stu_q;
                    wr_seat_no    <= seat_q;
                    code_q        <= RESP_OK;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b1;
                    resp_code  <= code_q;
                    resp_seat  <= (code_q == RESP_OK) ? seat_q : '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seat_allocator.sv
// Self-checking bench for seat_allocator: directed scenarios plus a randomized run
// against a seat-array reference model.
module tb_seat_allocator;

    localparam int NS = 32;

    logic        clk_alloc = 1'b0;
    logic        rst_n_alloc = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [24:0] req_student_no = '0;
    logic [7:0]  req_pref_seat = '0;
    logic        rel_valid = 1'b0;
    logic [7:0]  rel_seat = '0;
    logic        wr_en;
    logic [24:0] wr_student_no;
    logic [7:0]  wr_seat_no;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic [7:0]  resp_seat;
    logic [5:0]  occ_count;
    logic        full;

    int n_cmp = 0;
    int n_bad = 0;

    bit          occ_m [NS];
    logic [24:0] stu_m [NS];

    seat_allocator #(.NUM_SEATS(NS)) dut (
        .clk_alloc     (clk_alloc),
        .rst_n_alloc   (rst_n_alloc),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_student_no(req_student_no),
        .req_pref_seat (req_pref_seat),
        .rel_valid     (rel_valid),
        .rel_seat      (rel_seat),
        .wr_en         (wr_en),
        .wr_student_no (wr_student_no),
        .wr_seat_no    (wr_seat_no),
        .resp_valid    (resp_valid),
        .resp_code     (resp_code),
        .resp_seat     (resp_seat),
        .occ_count     (occ_count),
        .full          (full)
    );

    always #5 clk_alloc = ~clk_alloc;

    // ---------------- reference model ----------------
    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NS; i++) c += int'(occ_m[i]);
        return c;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) begin
            occ_m[i] = 1'b0;
            stu_m[i] = '0;
        end
    endfunction

    // code: 0 OK, 1 FULL, 2 DUP; steps = seats examined past the preferred one
    function automatic void model_req(input logic [24:0] stu, input int pref,
                                      output int code, output int seat, output int steps);
        int p = (pref >= NS) ? 0 : pref;
        code = 0; seat = 0; steps = 0;
        if (model_count() == NS) begin
            code = 1;
            return;
        end
`ifdef DUP_CHECK_EN
        for (int i = 0; i < NS; i++)
            if (occ_m[i] && stu_m[i] == stu) begin
                code = 2;
                return;
            end
`endif
        for (int d = 0; d < NS; d++) begin
            int s = (p + d) % NS;
            if (!occ_m[s]) begin
                seat = s; steps = d;
                occ_m[s] = 1'b1; stu_m[s] = stu;
                return;
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        rst_n_alloc = 1'b0; req_valid = 1'b0; rel_valid = 1'b0;
        repeat (2) @(posedge clk_alloc);
        #1 rst_n_alloc = 1'b1;
        model_clear();
        @(posedge clk_alloc); #1;
    endtask

    task automatic rel_pulse(input int s);
        rel_valid = 1'b1; rel_seat = 8'(s);
        @(posedge clk_alloc); #1;
        rel_valid = 1'b0;
        if (s < NS) occ_m[s] = 1'b0;
    endtask

    // Issues one request; cycles are counted from the handshake edge. A release of
    // rel_s is driven during cycle rel_at (rel_at < 0: none). rc = -1 on timeout.
    task automatic do_req(input logic [24:0] stu, input logic [7:0] pref,
                          input int rel_at, input logic [7:0] rel_s,
                          output int wc, output int rc, output int nwr,
                          output logic [7:0] ws, output logic [24:0] wstu,
                          output logic [1:0] code, output logic [7:0] rs);
        int k = 0;
        wc = -1; rc = -1; nwr = 0; ws = '0; wstu = '0; code = 2'b11; rs = '1;
        while (!req_ready && k < 50) begin
            @(posedge clk_alloc); #1; k++;
        end
        req_valid = 1'b1; req_student_no = stu; req_pref_seat = pref;
        @(posedge clk_alloc); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 80 && rc < 0; c++) begin
            if (c - 1 == rel_at) begin
                rel_valid = 1'b1; rel_seat = rel_s;
            end
            @(posedge clk_alloc); #1;
            rel_valid = 1'b0;
            if (wr_en) begin
                nwr++; wc = c; ws = wr_seat_no; wstu = wr_student_no;
            end
            if (resp_valid) begin
                rc = c; code = resp_code; rs = resp_seat;
            end
        end
    endtask

    task automatic seed(input logic [24:0] stu, input int pref);
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        do_req(stu, 8'(pref), -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(stu, pref, ec, es, st);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (occ_count !== 6'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occ_count); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if ({wr_seat_no, wr_student_no, resp_code, resp_seat} !== '0)
            begin n_bad++; $display("FAIL reset_outputs got %h want 0", {wr_seat_no, wr_student_no, resp_code, resp_seat}); end
    endtask

    task automatic test_pref_free();
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        do_req(25'd1001, 8'd5, -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(25'd1001, 5, ec, es, st);
        n_cmp++; if (wc !== 2) begin n_bad++; $display("FAIL pref_wr_cycle got %0d want 2", wc); end
        n_cmp++; if (ws !== 8'd5 || wstu !== 25'd1001) begin n_bad++; $display("FAIL pref_wr_data got %0d/%0d want 5/1001", ws, wstu); end
        n_cmp++; if (rc !== 3) begin n_bad++; $display("FAIL pref_resp_cycle got %0d want 3", rc); end
        n_cmp++; if (code !== 2'b00 || rs !== 8'(es)) begin n_bad++; $display("FAIL pref_resp got %b/%0d want 00/%0d", code, rs, es); end
        n_cmp++; if (occ_count !== 6'd1) begin n_bad++; $display("FAIL pref_occ got %0d want 1", occ_count); end
    endtask

    task automatic test_scan_one();
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        do_req(25'd1002, 8'd5, -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(25'd1002, 5, ec, es, st);
        n_cmp++; if (rc !== 4 || wc !== 3) begin n_bad++; $display("FAIL scan1_cycles got wr %0d resp %0d want 3/4", wc, rc); end
        n_cmp++; if (code !== 2'b00 || rs !== 8'd6) begin n_bad++; $display("FAIL scan1_resp got %b/%0d want 00/6", code, rs); end
        n_cmp++; if (occ_count !== 6'(model_count())) begin n_bad++; $display("FAIL scan1_occ got %0d want %0d", occ_count, model_count()); end
    endtask

    task automatic test_wrap();
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        apply_reset();
        seed(25'd1, 31);
        seed(25'd2, 0);
        do_req(25'd3, 8'd31, -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(25'd3, 31, ec, es, st);
        n_cmp++; if (code !== 2'b00 || rs !== 8'd1) begin n_bad++; $display("FAIL wrap_resp got %b/%0d want 00/1", code, rs); end
        n_cmp++; if (rc !== 3 + st || wc !== 2 + st) begin n_bad++; $display("FAIL wrap_cycles got wr %0d resp %0d want %0d/%0d", wc, rc, 2 + st, 3 + st); end
    endtask

    task automatic test_full();
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        apply_reset();
        for (int i = 0; i < NS; i++) seed(25'(100 + i), i);
        n_cmp++; if (full !== 1'b1 || occ_count !== 6'd32) begin n_bad++; $display("FAIL full_flag got %b/%0d want 1/32", full, occ_count); end
        do_req(25'd2000, 8'd7, -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(25'd2000, 7, ec, es, st);
        n_cmp++; if (code !== 2'b01 || rs !== 8'd0) begin n_bad++; $display("FAIL full_resp got %b/%0d want 01/0", code, rs); end
        n_cmp++; if (rc !== 2 || nwr !== 0) begin n_bad++; $display("FAIL full_timing got resp %0d writes %0d want 2/0", rc, nwr); end
        n_cmp++; if (occ_count !== 6'd32) begin n_bad++; $display("FAIL full_occ got %0d want 32", occ_count); end
        n_cmp++; if (wr_seat_no !== 8'd31 || wr_student_no !== 25'd131)
            begin n_bad++; $display("FAIL full_wr_hold got %0d/%0d want 31/131", wr_seat_no, wr_student_no); end
    endtask

    task automatic test_release_scan();
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        rel_pulse(3);
        n_cmp++; if (occ_count !== 6'd31 || full !== 1'b0) begin n_bad++; $display("FAIL rel_occ got %0d/%b want 31/0", occ_count, full); end
        do_req(25'd3000, 8'd15, 1, 8'd20, wc, rc, nwr, ws, wstu, code, rs);
        occ_m[20] = 1'b0;
        model_req(25'd3000, 15, ec, es, st);
        n_cmp++; if (code !== 2'b00 || rs !== 8'd20) begin n_bad++; $display("FAIL relscan_resp got %b/%0d want 00/20", code, rs); end
        n_cmp++; if (rc !== 3 + st) begin n_bad++; $display("FAIL relscan_cycle got %0d want %0d", rc, 3 + st); end
        rel_pulse(3);
        n_cmp++; if (occ_count !== 6'd31) begin n_bad++; $display("FAIL rel_free_noop got %0d want 31", occ_count); end
        rel_pulse(200);
        n_cmp++; if (occ_count !== 6'd31) begin n_bad++; $display("FAIL rel_oor_noop got %0d want 31", occ_count); end
    endtask

    task automatic test_write_release();
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        do_req(25'd4000, 8'd3, 1, 8'd7, wc, rc, nwr, ws, wstu, code, rs);
        occ_m[7] = 1'b0;
        model_req(25'd4000, 3, ec, es, st);
        n_cmp++; if (wc !== 2 || ws !== 8'd3) begin n_bad++; $display("FAIL wrrel_write got cyc %0d seat %0d want 2/3", wc, ws); end
        n_cmp++; if (occ_count !== 6'd31 || full !== 1'b0) begin n_bad++; $display("FAIL wrrel_occ got %0d/%b want 31/0", occ_count, full); end
        do_req(25'd4001, 8'd7, -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(25'd4001, 7, ec, es, st);
        n_cmp++; if (rs !== 8'd7 || occ_count !== 6'd32 || full !== 1'b1)
            begin n_bad++; $display("FAIL wrrel_refill got seat %0d occ %0d full %b want 7/32/1", rs, occ_count, full); end
    endtask

    task automatic test_dup();
        int wc, rc, nwr, ec, es, st;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code;
        apply_reset();
        seed(25'd1001, 9);
        do_req(25'd1001, 8'd9, -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(25'd1001, 9, ec, es, st);
`ifdef DUP_CHECK_EN
        n_cmp++; if (code !== 2'b10 || rs !== 8'd0) begin n_bad++; $display("FAIL dup_resp got %b/%0d want 10/0", code, rs); end
        n_cmp++; if (rc !== 2 || nwr !== 0) begin n_bad++; $display("FAIL dup_timing got resp %0d writes %0d want 2/0", rc, nwr); end
        rel_pulse(9);
        do_req(25'd1001, 8'd9, -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
        model_req(25'd1001, 9, ec, es, st);
        n_cmp++; if (code !== 2'b00 || rs !== 8'd9) begin n_bad++; $display("FAIL dup_after_rel got %b/%0d want 00/9", code, rs); end
`else
        n_cmp++; if (code !== 2'b00 || rs !== 8'd10) begin n_bad++; $display("FAIL dup_second_seat got %b/%0d want 00/10", code, rs); end
        n_cmp++; if (occ_count !== 6'd2) begin n_bad++; $display("FAIL dup_occ got %0d want 2", occ_count); end
`endif
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        apply_reset();
        for (int i = 5; i <= 8; i++) seed(25'(500 + i), i);
        req_valid = 1'b1; req_student_no = 25'd777; req_pref_seat = 8'd5;
        @(posedge clk_alloc); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk_alloc); #1; end
        rst_n_alloc = 1'b0;
        #1;
        n_cmp++; if (wr_en !== 1'b0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_strobes got %b/%b want 0/0", wr_en, resp_valid); end
        n_cmp++; if (occ_count !== 6'd0 || full !== 1'b0) begin n_bad++; $display("FAIL midrst_occ got %0d/%b want 0/0", occ_count, full); end
        n_cmp++; if (req_ready !== 1'b1 || resp_code !== 2'b00 || resp_seat !== 8'd0)
            begin n_bad++; $display("FAIL midrst_outputs got %b/%b/%0d want 1/00/0", req_ready, resp_code, resp_seat); end
        repeat (2) @(posedge clk_alloc);
        #1 rst_n_alloc = 1'b1;
        model_clear();
        repeat (12) begin
            @(posedge clk_alloc); #1;
            if (wr_en || resp_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_resp got %0d pulses want 0", seen); end
    endtask

    task automatic test_random();
        int wc, rc, nwr, ec, es, st, s;
        logic [7:0] ws, rs; logic [24:0] wstu; logic [1:0] code; logic [24:0] stu;
        apply_reset();
        for (int it = 0; it < 260; it++) begin
            if ($urandom_range(0, 9) < ((it < 120) ? 9 : 5)) begin
                stu = 25'($urandom_range(0, 63));
                s = $urandom_range(0, 39);
                do_req(stu, 8'(s), -1, 8'd0, wc, rc, nwr, ws, wstu, code, rs);
                model_req(stu, s, ec, es, st);
                n_cmp++; if (code !== 2'(ec) || rs !== ((ec == 0) ? 8'(es) : 8'd0))
                    begin n_bad++; $display("FAIL rnd_resp it %0d got %b/%0d want %0d/%0d", it, code, rs, ec, (ec == 0) ? es : 0); end
                n_cmp++; if (rc !== ((ec == 0) ? 3 + st : 2) || nwr !== ((ec == 0) ? 1 : 0))
                    begin n_bad++; $display("FAIL rnd_timing it %0d got resp %0d writes %0d want %0d/%0d", it, rc, nwr, (ec == 0) ? 3 + st : 2, (ec == 0) ? 1 : 0); end
                if (ec == 0) begin
                    n_cmp++; if (wc !== 2 + st || ws !== 8'(es) || wstu !== stu)
                        begin n_bad++; $display("FAIL rnd_write it %0d got %0d/%0d/%0d want %0d/%0d/%0d", it, wc, ws, wstu, 2 + st, es, stu); end
                end
            end else begin
                rel_pulse($urandom_range(0, 39));
            end
            n_cmp++; if (occ_count !== 6'(model_count()) || full !== (model_count() == NS))
                begin n_bad++; $display("FAIL rnd_occ it %0d got %0d/%b want %0d", it, occ_count, full, model_count()); end
        end
    endtask

    initial begin
        test_reset();
        test_pref_free();
        test_scan_one();
        test_wrap();
        test_full();
        test_release_scan();
        test_write_release();
        test_dup();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
